// File: rtl/stage_ir_nway_pkg.sv
// Shared types for the N-wide retire stage: bus/size/error encodings,
// per-lane ROB->retire and retire->{free list, map table, pipeline} packets,
// and the committed-store buffer entry.
package stage_ir_nway_pkg;

  localparam int XLEN   = 32;
  localparam int PHYS_W = 6;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [3:0] {
    NO_ERROR      = 4'h0,
    ILLEGAL_INST  = 4'h2,
    HALTED_ON_WFI = 4'hb
  } EXCEPTION_CODE;

  typedef struct packed {
    logic              retire_en;
    logic              wr_mem;
    logic              halt;
    logic              take_branch;
    logic [4:0]        dest_reg_idx;
    logic [PHYS_W-1:0] retire_t;
    logic [PHYS_W-1:0] retire_t_old;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   rs2_value;
    MEM_SIZE           mem_size;
    logic [XLEN-1:0]   NPC;
  } ROB_IR_PACKET;

  typedef struct packed {
    logic              retire_en;
    logic [PHYS_W-1:0] retire_t;
    logic [PHYS_W-1:0] retire_t_old;
  } IR_FL_PACKET;

  typedef struct packed {
    logic              retire_en;
    logic [4:0]        dest_reg_idx;
    logic [PHYS_W-1:0] retire_t;
    logic [PHYS_W-1:0] retire_t_old;
  } IR_MT_PACKET;

  typedef struct packed {
    logic [3:0]      completed_insts;
    EXCEPTION_CODE   error_status;
    logic            wr_en;
    logic [4:0]      dest_reg_idx;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] NPC;
  } IR_PIPELINE_PACKET;

  typedef struct packed {
    MEM_SIZE         size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } SB_ENTRY;

endpackage

// File: rtl/store_buffer.sv
// Circular FIFO of committed stores.
//   clock, reset : system clock, synchronous active-high reset (empties FIFO)
//   push_valid   : per-lane push strobes; set lanes are written in lane order
//   push_data    : per-lane entries
//   pop          : retire the head entry (ignored when empty)
//   head         : oldest entry
//   count        : occupancy
// The caller guarantees pushes never exceed the free space.
module store_buffer
  import stage_ir_nway_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PUSH_W = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PUSH_W-1:0]          push_valid,
  input  SB_ENTRY                    push_data [PUSH_W],
  input  logic                       pop,
  output SB_ENTRY                    head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(PUSH_W+1);

  SB_ENTRY       mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] slot [PUSH_W];
  logic [NW-1:0] push_n;
  logic          do_pop;

  // Sparse push strobes are compacted: each set lane takes the next free slot.
  always_comb begin
    push_n = '0;
    for (int unsigned i = 0; i < PUSH_W; i++) begin
      slot[i] = tail_ptr + PW'(push_n);
      if (push_valid[i]) push_n = push_n + NW'(1);
    end
  end

  assign do_pop = pop && (count != '0);
  assign head   = mem[head_ptr];

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < PUSH_W; i++) begin
      if (push_valid[i]) mem[slot[i]] <= push_data[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      tail_ptr <= tail_ptr + PW'(push_n);
      if (do_pop) head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(push_n) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/stage_ir_nway.sv
// N-wide in-order retire stage with a committed-store buffer.
//   clock, reset        : system clock, synchronous active-high reset
//   rob_ir_packet       : ROB head lanes, lane 0 oldest
//   store_grant         : Dmem accepted the presented store
//   retire_count        : accepted prefix length (ROB pops this many)
//   fl/mt/pipe_packet   : per-lane free-list, map-table and debug outputs
//   interrupt           : a taken branch retired this cycle
//   branch_target       : that branch's result
//   halted              : sticky, set the cycle after a halt retires
//   sb_count            : store-buffer occupancy
//   store2Dmem_*        : store-buffer head presented to Dmem
module stage_ir_nway
  import stage_ir_nway_pkg::*;
#(
  parameter int RETIRE_WIDTH = 2,
  parameter int SB_DEPTH     = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  ROB_IR_PACKET                      rob_ir_packet [RETIRE_WIDTH],
  input  logic                              store_grant,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_count,
  output IR_FL_PACKET                       fl_packet [RETIRE_WIDTH],
  output IR_MT_PACKET                       mt_packet [RETIRE_WIDTH],
  output IR_PIPELINE_PACKET                 pipe_packet [RETIRE_WIDTH],
  output logic                              interrupt,
  output logic [XLEN-1:0]                   branch_target,
  output logic                              halted,
  output logic [$clog2(SB_DEPTH+1)-1:0]     sb_count,
  output BUS_COMMAND                        store2Dmem_command,
  output MEM_SIZE                           store2Dmem_size,
  output logic [XLEN-1:0]                   store2Dmem_addr,
  output logic [XLEN-1:0]                   store2Dmem_data
);

  localparam int RCW  = $clog2(RETIRE_WIDTH+1);
  localparam int SBCW = $clog2(SB_DEPTH+1);

  logic [RETIRE_WIDTH-1:0] accepted;
  logic [RETIRE_WIDTH-1:0] push_valid;
  SB_ENTRY                 push_data [RETIRE_WIDTH];
  SB_ENTRY                 sb_head;
  logic                    blocked;
  logic                    lane_ok;
  logic                    halt_accept;
  logic [SBCW-1:0]         stores;
  logic [SBCW:0]           occ;

  // Prefix acceptance. occ counts buffer entries plus stores already accepted
  // this cycle; a same-cycle pop is deliberately not credited as free space.
  always_comb begin
    accepted      = '0;
    retire_count  = '0;
    stores        = '0;
    occ           = '0;
    lane_ok       = 1'b0;
    blocked       = reset || halted;
    interrupt     = 1'b0;
    branch_target = '0;
    halt_accept   = 1'b0;
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      occ     = (SBCW+1)'(sb_count) + (SBCW+1)'(stores);
      lane_ok = !blocked && rob_ir_packet[i].retire_en;
      if (rob_ir_packet[i].wr_mem && (occ >= (SBCW+1)'(SB_DEPTH))) lane_ok = 1'b0;
      if (rob_ir_packet[i].halt && (occ != '0)) lane_ok = 1'b0;
      accepted[i] = lane_ok;
      if (!lane_ok) begin
        blocked = 1'b1;
      end else begin
        retire_count = retire_count + RCW'(1);
        if (rob_ir_packet[i].wr_mem) stores = stores + SBCW'(1);
        if (rob_ir_packet[i].take_branch) begin
          interrupt     = 1'b1;
          branch_target = rob_ir_packet[i].result;
          blocked       = 1'b1;
        end
        if (rob_ir_packet[i].halt) begin
          halt_accept = 1'b1;
          blocked     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < RETIRE_WIDTH; i++) begin
      fl_packet[i].retire_en    = accepted[i];
      fl_packet[i].retire_t     = rob_ir_packet[i].retire_t;
      fl_packet[i].retire_t_old = rob_ir_packet[i].retire_t_old;

      mt_packet[i].retire_en    = accepted[i];
      mt_packet[i].dest_reg_idx = rob_ir_packet[i].dest_reg_idx;
      mt_packet[i].retire_t     = rob_ir_packet[i].retire_t;
      mt_packet[i].retire_t_old = rob_ir_packet[i].retire_t_old;

      pipe_packet[i].completed_insts = accepted[i] ? 4'd1 : 4'd0;
      pipe_packet[i].error_status    = (accepted[i] && rob_ir_packet[i].halt) ? HALTED_ON_WFI : NO_ERROR;
      pipe_packet[i].wr_en           = accepted[i] && (rob_ir_packet[i].dest_reg_idx != ZERO_REG);
      pipe_packet[i].dest_reg_idx    = rob_ir_packet[i].dest_reg_idx;
      pipe_packet[i].wr_data         = rob_ir_packet[i].result;
      pipe_packet[i].NPC             = rob_ir_packet[i].take_branch ? rob_ir_packet[i].result
                                                                    : rob_ir_packet[i].NPC;

      push_valid[i]     = accepted[i] && rob_ir_packet[i].wr_mem;
      push_data[i].size = rob_ir_packet[i].mem_size;
      push_data[i].addr = rob_ir_packet[i].result;
      push_data[i].data = rob_ir_packet[i].rs2_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) halted <= 1'b0;
    else if (halt_accept) halted <= 1'b1;
  end

  store_buffer #(
    .DEPTH  (SB_DEPTH),
    .PUSH_W (RETIRE_WIDTH)
  ) u_store_buffer (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop        (store_grant),
    .head       (sb_head),
    .count      (sb_count)
  );

  assign store2Dmem_command = (sb_count != '0) ? BUS_STORE : BUS_NONE;
  assign store2Dmem_size    = sb_head.size;
  assign store2Dmem_addr    = sb_head.addr;
  assign store2Dmem_data    = sb_head.data;

endmodule

// File: tb/tb_stage_ir_nway.sv
module tb_stage_ir_nway;
  import stage_ir_nway_pkg::*;

  localparam int RW = 2;
  localparam int SD = 4;

  typedef enum {K_NONE, K_ALU, K_ST, K_BR, K_HALT} kind_e;

  typedef struct {
    kind_e       k0, k1;
    logic [4:0]  d0, d1;
    logic [31:0] r0, r1;
    logic        grant;
    logic [1:0]  exp_cnt;
    logic [1:0]  exp_wr;
    logic        exp_int;
    logic [31:0] exp_tgt;
    logic [2:0]  exp_sb;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset;
  ROB_IR_PACKET      rob [RW];
  logic              store_grant;
  logic [1:0]        retire_count;
  IR_FL_PACKET       fl [RW];
  IR_MT_PACKET       mt [RW];
  IR_PIPELINE_PACKET pipe [RW];
  logic              interrupt;
  logic [XLEN-1:0]   branch_target;
  logic              halted;
  logic [2:0]        sb_count;
  BUS_COMMAND        cmd;
  MEM_SIZE           sz;
  logic [XLEN-1:0]   addr, data;

  int      n_cmp = 0;
  int      n_bad = 0;
  SB_ENTRY sbq[$];
  vec_t    vt[13];

  always #5 clock = ~clock;

  stage_ir_nway #(.RETIRE_WIDTH(RW), .SB_DEPTH(SD)) dut (
    .clock              (clock),
    .reset              (reset),
    .rob_ir_packet      (rob),
    .store_grant        (store_grant),
    .retire_count       (retire_count),
    .fl_packet          (fl),
    .mt_packet          (mt),
    .pipe_packet        (pipe),
    .interrupt          (interrupt),
    .branch_target      (branch_target),
    .halted             (halted),
    .sb_count           (sb_count),
    .store2Dmem_command (cmd),
    .store2Dmem_size    (sz),
    .store2Dmem_addr    (addr),
    .store2Dmem_data    (data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ROB_IR_PACKET mk(input kind_e k, input logic [4:0] d, input logic [31:0] r);
    ROB_IR_PACKET p;
    p              = '0;
    p.retire_en    = (k != K_NONE);
    p.wr_mem       = (k == K_ST);
    p.halt         = (k == K_HALT);
    p.take_branch  = (k == K_BR);
    p.dest_reg_idx = (k == K_ALU) ? d : ZERO_REG;
    p.retire_t     = {1'b1, d};
    p.retire_t_old = {1'b0, d};
    p.result       = r;
    p.rs2_value    = r ^ 32'hA5A5_0000;
    p.mem_size     = WORD;
    p.NPC          = 32'h4000_0000 | r;
    return p;
  endfunction

  function automatic SB_ENTRY exp_entry(input logic [31:0] r);
    SB_ENTRY e;
    e.size = WORD;
    e.addr = r;
    e.data = r ^ 32'hA5A5_0000;
    return e;
  endfunction

  // Called at the negedge: a granted cycle retires the scoreboard head.
  task automatic sb_monitor();
    SB_ENTRY e;
    if (store_grant) begin
      if (sbq.size() == 0) begin
        chk("cmd_idle", cmd, BUS_NONE);
      end else begin
        e = sbq.pop_front();
        chk("cmd_store", cmd, BUS_STORE);
        chk("st_addr", addr, e.addr);
        chk("st_data", data, e.data);
        chk("st_size", sz, e.size);
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [1:0] mask;
    logic [31:0] npc0;
    bit done;

    //       k0      k1      d0 d1  r0          r1          g  cnt wr  int tgt        sb
    vt[0]  = '{K_ALU,  K_ALU,  5, 0, 32'h10,     32'h20,     0, 2, 2'b01, 0, 32'h0,   0};
    vt[1]  = '{K_NONE, K_ALU,  0, 7, 32'h0,      32'h30,     0, 0, 2'b00, 0, 32'h0,   0};
    vt[2]  = '{K_BR,   K_ALU,  0, 7, 32'h100,    32'h40,     0, 1, 2'b00, 1, 32'h100, 0};
    vt[3]  = '{K_ALU,  K_BR,   3, 0, 32'h50,     32'h200,    0, 2, 2'b01, 1, 32'h200, 0};
    vt[4]  = '{K_ST,   K_HALT, 0, 0, 32'h1010,   32'h0,      0, 1, 2'b00, 0, 32'h0,   0};
    vt[5]  = '{K_ST,   K_ALU,  0, 7, 32'h1020,   32'h60,     0, 2, 2'b10, 0, 32'h0,   1};
    vt[6]  = '{K_ST,   K_ALU,  0, 7, 32'h1030,   32'h64,     0, 2, 2'b10, 0, 32'h0,   2};
    vt[7]  = '{K_ST,   K_ST,   0, 0, 32'h1040,   32'h1050,   0, 1, 2'b00, 0, 32'h0,   3};
    vt[8]  = '{K_ST,   K_ALU,  0, 7, 32'h1050,   32'h68,     0, 0, 2'b00, 0, 32'h0,   4};
    vt[9]  = '{K_ST,   K_ALU,  0, 7, 32'h1050,   32'h68,     1, 0, 2'b00, 0, 32'h0,   4};
    vt[10] = '{K_ST,   K_ALU,  0, 7, 32'h1050,   32'h68,     0, 2, 2'b10, 0, 32'h0,   3};
    vt[11] = '{K_ALU,  K_ALU,  1, 2, 32'h70,     32'h74,     1, 2, 2'b11, 0, 32'h0,   4};
    vt[12] = '{K_ST,   K_NONE, 0, 0, 32'h1060,   32'h0,      0, 1, 2'b00, 0, 32'h0,   3};

    // Reset: lanes valid but nothing may retire.
    reset       = 1'b1;
    store_grant = 1'b0;
    rob[0]      = mk(K_ALU, 5'd1, 32'h1);
    rob[1]      = mk(K_ALU, 5'd2, 32'h2);
    @(negedge clock);
    chk("rst_cnt", retire_count, 0);
    chk("rst_fl_en", {fl[1].retire_en, fl[0].retire_en}, 0);
    chk("rst_wr_en", {pipe[1].wr_en, pipe[0].wr_en}, 0);
    chk("rst_sb", sb_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cmd", cmd, BUS_NONE);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      v = vt[i];
      rob[0] = mk(v.k0, v.d0, v.r0);
      rob[1] = mk(v.k1, v.d1, v.r1);
      store_grant = v.grant;
      mask = (v.exp_cnt == 2) ? 2'b11 : (v.exp_cnt == 1) ? 2'b01 : 2'b00;
      npc0 = (v.k0 == K_BR) ? v.r0 : (32'h4000_0000 | v.r0);
      @(negedge clock);
      chk($sformatf("v%0d_cnt", i), retire_count, v.exp_cnt);
      chk($sformatf("v%0d_wr_en", i), {pipe[1].wr_en, pipe[0].wr_en}, v.exp_wr);
      chk($sformatf("v%0d_fl_en", i), {fl[1].retire_en, fl[0].retire_en}, mask);
      chk($sformatf("v%0d_mt_en", i), {mt[1].retire_en, mt[0].retire_en}, mask);
      chk($sformatf("v%0d_done1", i), pipe[1].completed_insts, (v.exp_cnt == 2) ? 1 : 0);
      chk($sformatf("v%0d_int", i), interrupt, v.exp_int);
      chk($sformatf("v%0d_tgt", i), branch_target, v.exp_tgt);
      chk($sformatf("v%0d_sb", i), sb_count, v.exp_sb);
      chk($sformatf("v%0d_npc0", i), pipe[0].NPC, npc0);
      chk($sformatf("v%0d_t0", i), fl[0].retire_t, {1'b1, v.d0});
      chk($sformatf("v%0d_halted", i), halted, 0);
      sb_monitor();
      @(posedge clock); #1;
      if (v.exp_cnt >= 1 && v.k0 == K_ST) sbq.push_back(exp_entry(v.r0));
      if (v.exp_cnt == 2 && v.k1 == K_ST) sbq.push_back(exp_entry(v.r1));
    end

    // Halt waits for the buffer to drain, then retires alone.
    rob[0] = mk(K_HALT, 5'd0, 32'h0);
    rob[1] = mk(K_ALU, 5'd4, 32'h78);
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      store_grant = (sbq.size() != 0);
      @(negedge clock);
      chk("halt_sb", sb_count, sbq.size());
      if (sbq.size() != 0) begin
        chk("halt_stall", retire_count, 0);
      end else begin
        chk("halt_cnt", retire_count, 1);
        chk("halt_err", pipe[0].error_status, HALTED_ON_WFI);
        chk("halt_done0", pipe[0].completed_insts, 1);
        chk("halt_done1", pipe[1].completed_insts, 0);
        chk("halt_err1", pipe[1].error_status, NO_ERROR);
        done = 1'b1;
      end
      sb_monitor();
      @(posedge clock); #1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL halt_timeout: got no halt retire, expected halt retire");
    end
    store_grant = 1'b0;
    rob[0] = mk(K_ALU, 5'd5, 32'h80);
    rob[1] = mk(K_BR, 5'd0, 32'h300);
    @(negedge clock);
    chk("post_halt_halted", halted, 1);
    chk("post_halt_cnt", retire_count, 0);
    chk("post_halt_int", interrupt, 0);
    chk("post_halt_cmd", cmd, BUS_NONE);
    @(posedge clock); #1;

    // Reset discards buffered stores and clears halted.
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sbq.delete();
    rob[0] = mk(K_ST, 5'd0, 32'h2000);
    rob[1] = mk(K_ST, 5'd0, 32'h2010);
    @(negedge clock);
    chk("rr_cnt_a", retire_count, 2);
    @(posedge clock); #1;
    rob[0] = mk(K_ST, 5'd0, 32'h2020);
    rob[1] = mk(K_NONE, 5'd0, 32'h0);
    @(negedge clock);
    chk("rr_cnt_b", retire_count, 1);
    @(posedge clock); #1;
    rob[0] = mk(K_NONE, 5'd0, 32'h0);
    @(negedge clock);
    chk("rr_sb3", sb_count, 3);
    chk("rr_cmd", cmd, BUS_STORE);
    chk("rr_head", addr, 32'h2000);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rr_sb0", sb_count, 0);
    chk("rr_cmd_none", cmd, BUS_NONE);
    chk("rr_halted", halted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
